// File: rtl/mul_issue_ctrl.sv
// Round-robin issue controller for the shared 32x32 multiplier: accepts requests from two
// pipes, sequences start/done with the multiplier and returns a tagged, word-selected result.
module mul_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_src1,
    input  logic [31:0]      req0_src2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_src1,
    input  logic [31:0]      req1_src2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             mul_start,
    output logic             mul_signed,
    output logic [31:0]      mul_reg1,
    output logic [31:0]      mul_reg2,
    input  logic             mul_done,
    input  logic [63:0]      mul_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_port
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_reg;
    logic             rr_ptr_reg;
    logic             drop_reg;
    logic [1:0]       op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             port_reg;
    logic             mul_signed_reg;
    logic [31:0]      mul_reg1_reg;
    logic [31:0]      mul_reg2_reg;
    logic             resp_valid_reg;
    logic [31:0]      resp_data_reg;
    logic [TAG_W-1:0] resp_tag_reg;
    logic             resp_port_reg;

    logic             grant;
    logic             accept;
    logic [1:0]       ready_vec;
    logic [1:0]       sel_op;
    logic [31:0]      sel_src1;
    logic [31:0]      sel_src2;
    logic [TAG_W-1:0] sel_tag;
    logic             hi_sel;

    // A lone valid port always wins; the pointer only breaks ties.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = rr_ptr_reg;
        end
    end

    assign accept = (state_reg == IDLE) && !flush && (req0_valid || req1_valid);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = accept && (grant == gi[0]);
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    assign sel_op   = grant ? req1_op   : req0_op;
    assign sel_src1 = grant ? req1_src1 : req0_src1;
    assign sel_src2 = grant ? req1_src2 : req0_src2;
    assign sel_tag  = grant ? req1_tag  : req0_tag;

    // MULH.W and MULH.WU return the upper word; MUL.W and the reserved code the lower.
    assign hi_sel = (op_reg == 2'b01) || (op_reg == 2'b10);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= 1'b0;
            drop_reg       <= 1'b0;
            op_reg         <= 2'b00;
            tag_reg        <= '0;
            port_reg       <= 1'b0;
            mul_signed_reg <= 1'b0;
            mul_reg1_reg   <= 32'd0;
            mul_reg2_reg   <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 32'd0;
            resp_tag_reg   <= '0;
            resp_port_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg         <= sel_op;
                        tag_reg        <= sel_tag;
                        port_reg       <= grant;
                        mul_reg1_reg   <= sel_src1;
                        mul_reg2_reg   <= sel_src2;
                        mul_signed_reg <= (sel_op != 2'b10);
                        rr_ptr_reg     <= ~grant;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        drop_reg <= 1'b1;
                    end
                    state_reg <= BUSY;
                end
                BUSY: begin
                    if (mul_done) begin
                        // A flush coinciding with done still discards the result.
                        if (drop_reg || flush) begin
                            drop_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            resp_valid_reg <= 1'b1;
                            resp_data_reg  <= hi_sel ? mul_result[63:32] : mul_result[31:0];
                            resp_tag_reg   <= tag_reg;
                            resp_port_reg  <= port_reg;
                            state_reg      <= RESP;
                        end
                    end else if (flush) begin
                        drop_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mul_start  = (state_reg == ISSUE);
    assign mul_signed = mul_signed_reg;
    assign mul_reg1   = mul_reg1_reg;
    assign mul_reg2   = mul_reg2_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_tag   = resp_tag_reg;
    assign resp_port  = resp_port_reg;

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencing controller and arbiter for the shared single-port 32x32 multiplier unit in the execute stage.
- Accepts multiply requests from two issue pipes (pipe 0, pipe 1) over valid/ready handshakes and arbitrates between them round-robin.
- Drives the multiplier's start/signed/operand inputs, waits for its done pulse, selects the low or high result word per opcode, and returns a tagged response.
- Supports pipeline flush; an in-flight multiply always runs to completion, and its result is discarded.

Parameters:
- TAG_W, 5, width of the request/response tag (ROB index).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset; synchronous, active-high (asserted = 1 resets the block).
- flush  in  1  pipeline flush; kills the pending request and any result.
- req0_valid  in  1  pipe 0 request valid.
- req0_ready  out  1  pipe 0 request accepted this cycle.
- req0_op  in  2  00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 reserved (treated as 00).
- req0_src1  in  32  operand 1.
- req0_src2  in  32  operand 2.
- req0_tag  in  TAG_W  request tag.
- req1_valid, req1_ready, req1_op, req1_src1, req1_src2, req1_tag: same as pipe 0, for pipe 1.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_signed  out  1  multiplier signed_op select.
- mul_reg1  out  32  multiplier operand 1.
- mul_reg2  out  32  multiplier operand 2.
- mul_done  in  1  multiplier completion pulse.
- mul_result  in  64  multiplier product.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  selected result word.
- resp_tag  out  TAG_W  tag of the completed request.
- resp_port  out  1  originating pipe (0 or 1).

Behaviour:
- FSM states: IDLE, ISSUE, BUSY, RESP.
- Reset (rstn=1 at a clock edge):
  - state=IDLE, rr_ptr=0, drop=0.
  - mul_start=0, mul_signed=0, mul_reg1=0, mul_reg2=0.
  - resp_valid=0, resp_data=0, resp_tag=0, resp_port=0.
  - Reset mid-operation abandons everything, with no response.
  - A stale mul_done arriving in IDLE is ignored.
- IDLE, arbitration:
  - grant = the single valid port if only one is valid.
  - If both are valid, grant = rr_ptr.
  - reqN_ready = (state==IDLE) & !flush & granted port N. Ready is combinational; at most one ready per cycle.
- IDLE, on handshake:
  - Latch op, operands, tag and port into internal registers.
  - rr_ptr <= ~granted port.
  - Next state ISSUE.
- ISSUE:
  - mul_start=1 for exactly this one cycle.
  - mul_reg1/mul_reg2 driven from latched operands; they hold stable until the next accept.
  - mul_signed = 1 for op 00/01/11, 0 for op 10.
  - Next state BUSY.
- BUSY:
  - Wait for mul_done; there is no timeout.
  - On mul_done with drop=0: resp_data <= mul_result[31:0] for op 00/11, mul_result[63:32] for op 01/10. Also load resp_tag and resp_port, set resp_valid=1, go to RESP.
  - On mul_done with drop=1: clear drop, go to IDLE, no response.
- Timing with a 1-cycle multiplier:
  - Accept edge → ISSUE at T+1 → mul_done at T+2 → resp_valid at T+3.
  - Minimum request-to-request spacing is 4 cycles when resp_ready is held at 1.
- RESP:
  - resp_valid held with stable data/tag/port until resp_ready=1. Then clear resp_valid and go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Flush:
  - In IDLE: no acceptance that cycle.
  - In ISSUE or BUSY: drop <= 1. The start pulse is still issued and the multiplier is not aborted.
  - In RESP: resp_valid <= 0, go to IDLE; this takes priority over resp_ready.
  - If flush and mul_done coincide in BUSY, the result is dropped.

Test Plan:
- Single request, resp_ready=1: req0 op=00, src1=0x00000007, src2=0xFFFFFFFE, tag=3. Expect resp_data=0xFFFFFFF2, resp_tag=3, resp_port=0, mul_signed=1, and resp_valid exactly 3 cycles after the accept edge.
- High word, signed vs unsigned: src1=src2=0xFFFFFFFF. op=01 → resp_data=0x00000000 with mul_signed=1. op=10 → resp_data=0xFFFFFFFE with mul_signed=0.
- Round-robin: both pipes continuously valid for 4 requests each. Grants alternate 0,1,0,1…; resp_port matches the grant order; the loser's ready stays 0 while the other port is granted.
- Backpressure: resp_ready=0 for 5 cycles in RESP. resp_valid, resp_data and resp_tag stay stable; req0_ready and req1_ready stay 0 until the handshake completes.
- Flush in BUSY: assert flush the cycle after mul_start. No resp_valid is produced; the FSM returns to IDLE after mul_done; the next request completes normally with the correct tag.
- Reset mid-operation: rstn=1 during BUSY, then mul_done arrives. All outputs are 0, no response is produced, and rr_ptr=0.
